// File: rtl/lpf_avg.sv
// Streaming TAPS-point moving-average (boxcar) filter for signed DATA_W-bit samples.
// Optional macro LPF_AVG_ROUND_EN selects round-half-up output instead of floor truncation.
module lpf_avg #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAPS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x_in,
  output logic [DATA_W-1:0] y_out
);

  localparam int unsigned LOG2_TAPS = $clog2(TAPS);
  localparam int unsigned ACC_W     = DATA_W + LOG2_TAPS;

  if (TAPS < 2 || TAPS > 256 || (TAPS & (TAPS - 1)) != 0) begin : g_bad_taps
    $error("lpf_avg: TAPS must be a power of two in 2..256");
  end

  logic signed [DATA_W-1:0] x_s;
  logic signed [DATA_W-1:0] d [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum_next;
  logic signed [DATA_W-1:0] y_next;

  assign x_s = x_in;

`ifdef LPF_AVG_ROUND_EN
  localparam int HALF = 1 << (LOG2_TAPS - 1);
  // One guard bit keeps +full-scale plus the rounding offset from wrapping.
  logic signed [ACC_W:0] sum_rnd;
`endif

  // Running sum: add newest sample, drop the one leaving the window.
  always_comb begin
    sum_next = acc + ACC_W'(x_s) - ACC_W'(d[TAPS-1]);
`ifdef LPF_AVG_ROUND_EN
    sum_rnd  = (ACC_W+1)'(sum_next) + (ACC_W+1)'(HALF);
    y_next   = DATA_W'(sum_rnd >>> LOG2_TAPS);
`else
    y_next   = DATA_W'(sum_next >>> LOG2_TAPS);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) d[i] <= '0;
      acc   <= '0;
      y_out <= '0;
    end else begin
      d[0] <= x_s;
      for (int unsigned i = 1; i < TAPS; i++) d[i] <= d[i-1];
      acc   <= sum_next;
      y_out <= y_next;
    end
  end

endmodule

// File: tb/tb_lpf_avg.sv
// Directed self-checking bench for lpf_avg (DATA_W=16, TAPS=8).
module tb_lpf_avg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x_in;
  logic [15:0] y_out;

  int total = 0;
  int bad   = 0;

  lpf_avg #(.DATA_W(16), .TAPS(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .x_in (x_in),
    .y_out(y_out)
  );

  always #5 clk = ~clk;

  // Apply one sample, clock it in, then compare the registered output.
  task automatic step(input int x, input logic r, input int exp, input string tag);
    x_in = 16'(x);
    rst  = r;
    @(posedge clk);
    #1;
    total++;
    assert (y_out === 16'(exp)) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(y_out), exp);
    end
  endtask

  task automatic drive(input int x, input logic r);
    x_in = 16'(x);
    rst  = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    x_in = 16'd0;

    // Reset held with a nonzero input
    step(1234, 1'b1, 0, "reset0");
    step(1234, 1'b1, 0, "reset1");
    step(0,    1'b0, 0, "post_reset_zero");

    // Step response ramps 100..800 then holds
    for (int k = 1; k <= 10; k++)
      step(800, 1'b0, (k < 8 ? k : 8) * 100, "step");

    // Impulse: 1000 for exactly 8 outputs, then 0
    step(0, 1'b1, 0, "impulse_rst");
    step(8000, 1'b0, 1000, "impulse");
    for (int k = 1; k <= 9; k++)
      step(0, 1'b0, (k < 8) ? 1000 : 0, "impulse_tail");

    // Negative impulse exposes output quantisation
    step(0, 1'b1, 0, "round_rst");
`ifdef LPF_AVG_ROUND_EN
    step(-3, 1'b0, 0, "round_imp");
    for (int k = 1; k <= 9; k++) step(0, 1'b0, 0, "round_tail");
`else
    step(-3, 1'b0, -1, "trunc_imp");
    for (int k = 1; k <= 9; k++)
      step(0, 1'b0, (k < 8) ? -1 : 0, "trunc_tail");
`endif

    // Positive full scale
    step(0, 1'b1, 0, "fs_pos_rst");
    for (int k = 1; k <= 7; k++) drive(32767, 1'b0);
    for (int k = 8; k <= 11; k++) step(32767, 1'b0, 32767, "fs_pos");

    // Negative full scale
    step(0, 1'b1, 0, "fs_neg_rst");
    for (int k = 1; k <= 7; k++) drive(-32768, 1'b0);
    for (int k = 8; k <= 11; k++) step(-32768, 1'b0, -32768, "fs_neg");

    // Alternating full scale: window sum settles to -4
    step(0, 1'b1, 0, "fs_alt_rst");
    for (int k = 1; k <= 7; k++) drive((k % 2) ? 32767 : -32768, 1'b0);
    for (int k = 8; k <= 11; k++)
`ifdef LPF_AVG_ROUND_EN
      step((k % 2) ? 32767 : -32768, 1'b0, 0, "fs_alt");
`else
      step((k % 2) ? 32767 : -32768, 1'b0, -1, "fs_alt");
`endif

    // Mid-stream reset discards history and restarts the ramp
    step(0, 1'b1, 0, "mid_rst_pre");
    for (int k = 1; k <= 4; k++) step(800, 1'b0, k * 100, "mid_ramp");
    step(800, 1'b1, 0, "mid_rst");
    for (int k = 1; k <= 3; k++) step(800, 1'b0, k * 100, "mid_restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
